// File: rtl/seg7_scan_display.sv
// Purpose: four-digit common-anode 7-seg driver with sequential binary-to-BCD conversion.
// Latency: 16-cycle conversion to bcd, +1 cycle to seg; each digit slot lasts SCAN_DIV cycles.
// Backpressure: none; value is sampled once per conversion and ignored in between.
module seg7_scan_display #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value,
    input  logic [2:0]  mode,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        busy,
    output logic [15:0] bcd
);

    localparam int PW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [3:0]     shift_cnt;
    logic [13:0]    sreg;
    logic [15:0]    acc;
    logic [15:0]    acc_adj;
    logic           ovf_work;
    logic           ovf_disp;
    logic [3:0]     blank;
    logic [3:0]     blank_nxt;
    logic [PW-1:0]  presc;
    logic [1:0]     idx;
    logic [3:0]     digit;
    logic [6:0]     glyph;
    logic [6:0]     seg_nxt;
    logic           dp_nxt;

    always_ff @(posedge clk) begin
        if (rst) state <= S_LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD:   state_nxt = S_SHIFT;
            S_SHIFT:  if (shift_cnt == 4'd13) state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = S_LOAD;
            default:  state_nxt = S_LOAD;
        endcase
    end

    assign busy = (state != S_COMMIT);

    // Double-dabble correction: bump every nibble >= 5 before the shift.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 4; i++) begin
            if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        blank_nxt    = 4'b0000;
        blank_nxt[3] = (acc[15:12] == 4'd0);
        blank_nxt[2] = blank_nxt[3] && (acc[11:8] == 4'd0);
        blank_nxt[1] = blank_nxt[2] && (acc[7:4] == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_cnt <= 4'd0;
            sreg      <= 14'd0;
            acc       <= 16'd0;
            ovf_work  <= 1'b0;
            bcd       <= 16'd0;
            ovf_disp  <= 1'b0;
            blank     <= 4'b1110;
        end else begin
            case (state)
                S_LOAD: begin
                    sreg      <= value[13:0];
                    acc       <= 16'd0;
                    ovf_work  <= (value > 32'd9999);
                    shift_cnt <= 4'd0;
                end
                S_SHIFT: begin
                    {acc, sreg} <= {acc_adj[14:0], sreg, 1'b0};
                    shift_cnt   <= shift_cnt + 4'd1;
                end
                S_COMMIT: begin
                    bcd      <= acc;
                    ovf_disp <= ovf_work;
                    blank    <= blank_nxt;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= 2'd0;
        end else if (presc == PW'(SCAN_DIV - 1)) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign digit = bcd[{idx, 2'b00} +: 4];

    always_comb begin
        glyph = 7'b1111111;
        case (digit)
            4'd0: glyph = 7'b1000000;
            4'd1: glyph = 7'b1111001;
            4'd2: glyph = 7'b0100100;
            4'd3: glyph = 7'b0110000;
            4'd4: glyph = 7'b0011001;
            4'd5: glyph = 7'b0010010;
            4'd6: glyph = 7'b0000010;
            4'd7: glyph = 7'b1111000;
            4'd8: glyph = 7'b0000000;
            4'd9: glyph = 7'b0010000;
            default: glyph = 7'b1111111;
        endcase
    end

    always_comb begin
        seg_nxt = glyph;
        if (ovf_disp)        seg_nxt = 7'b0111111;
        else if (blank[idx]) seg_nxt = 7'b1111111;
        dp_nxt = !(((idx == 2'd0) && (mode == 3'b001)) ||
                   ((idx == 2'd1) && (mode == 3'b010)) ||
                   ((idx == 2'd2) && (mode == 3'b100)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= 7'b1111111;
            dp  <= 1'b1;
            an  <= 4'b1111;
        end else begin
            seg <= seg_nxt;
            dp  <= dp_nxt;
            an  <= ~(4'b0001 << idx);
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: directed and random values checked against a decimal-arithmetic
// model of what each digit position should show.
module tb_seg7_scan_display;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] value;
    logic [2:0]  mode;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        busy;
    logic [15:0] bcd;

    int checks   = 0;
    int failures = 0;

    seg7_scan_display #(.SCAN_DIV(SD)) dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .mode  (mode),
        .seg   (seg),
        .dp    (dp),
        .an    (an),
        .busy  (busy),
        .bcd   (bcd)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] glyph_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int pow10(input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    // What digit position k should show for value v.
    function automatic logic [6:0] exp_seg(input logic [31:0] v, input int k);
        int vi;
        if (v > 32'd9999) return 7'b0111111;
        vi = int'(v);
        if (k > 0 && vi < pow10(k)) return 7'b1111111;
        return glyph_of((vi / pow10(k)) % 10);
    endfunction

    function automatic logic [15:0] exp_bcd(input logic [31:0] v);
        logic [15:0] r;
        int vi = int'(v);
        for (int k = 0; k < 4; k++) r[4*k +: 4] = 4'((vi / pow10(k)) % 10);
        return r;
    endfunction

    function automatic logic exp_dp(input logic [2:0] m, input int k);
        if (m == 3'b001 && k == 0) return 1'b0;
        if (m == 3'b010 && k == 1) return 1'b0;
        if (m == 3'b100 && k == 2) return 1'b0;
        return 1'b1;
    endfunction

    // Advance until the edge that ends the next COMMIT cycle; n accumulates cycles spent.
    task automatic wait_commit(inout int n);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b0) begin
                seen = 1'b1;
                break;
            end
            tick();
            n++;
        end
        chk("commit_seen", 32'(seen), 32'd1);
        tick();
        n++;
    endtask

    task automatic scan_check(input logic [31:0] v, input logic [2:0] m);
        int prevk = -1;
        int run = 0;
        int changes = 0;
        logic [3:0] seen = 4'b0000;
        for (int c = 0; c < 5 * SD + 1; c++) begin
            int k;
            case (an)
                4'b1110: k = 0;
                4'b1101: k = 1;
                4'b1011: k = 2;
                4'b0111: k = 3;
                default: k = -1;
            endcase
            chk("an_onehot", 32'(k >= 0), 32'd1);
            if (k >= 0) begin
                chk("seg", 32'(seg), 32'(exp_seg(v, k)));
                chk("dp", 32'(dp), 32'(exp_dp(m, k)));
                seen[k] = 1'b1;
                if (prevk >= 0 && k != prevk) begin
                    if (changes > 0) chk("slot_len", 32'(run), 32'(SD));
                    chk("idx_step", 32'(k), 32'((prevk + 1) % 4));
                    changes++;
                    run = 0;
                end
                run++;
                prevk = k;
            end
            tick();
        end
        chk("all_digits", 32'(seen), 32'hF);
    endtask

    task automatic apply(input logic [31:0] v, input logic [2:0] m);
        int n = 0;
        value = v;
        mode  = m;
        wait_commit(n);
        wait_commit(n);
        if (v <= 32'd9999) begin
            chk("bcd", 32'(bcd), 32'(exp_bcd(v)));
            chk("latency", 32'(n <= 32), 32'd1);
        end
        tick();
        scan_check(v, m);
    endtask

    initial begin
        logic [2:0] modes [5];
        int n;
        modes[0] = 3'b001; modes[1] = 3'b010; modes[2] = 3'b100;
        modes[3] = 3'b000; modes[4] = 3'b011;

        rst   = 1'b1;
        value = 32'd0;
        mode  = 3'b001;
        tick(); tick(); tick();
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_bcd", 32'(bcd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);

        rst = 1'b0;
        tick();
        chk("boot_an", 32'(an), 32'hE);
        chk("boot_seg", 32'(seg), 32'(7'b1000000));
        chk("boot_dp", 32'(dp), 32'(exp_dp(3'b001, 0)));
        chk("boot_bcd", 32'(bcd), 32'd0);

        apply(32'd1234, 3'b001);
        apply(32'd7, 3'b010);
        apply(32'd100, 3'b100);
        apply(32'd9999, 3'b000);
        apply(32'd10000, 3'b011);
        apply(32'hFFFF_FFFF, 3'b001);
        apply(32'd0, 3'b010);

        for (int it = 0; it < 8; it++) begin
            logic [31:0] v;
            if ($urandom_range(0, 3) == 0) v = $urandom;
            else                           v = 32'($urandom_range(0, 9999));
            apply(v, modes[$urandom_range(0, 4)]);
        end

        // Value change on the 5th SHIFT cycle must not disturb the conversion in flight.
        apply(32'd1111, 3'b001);
        n = 0;
        wait_commit(n);
        value = 32'd4321;
        tick(); tick(); tick(); tick(); tick();
        value = 32'd5678;
        wait_commit(n);
        chk("mid_old", 32'(bcd), 32'h4321);
        wait_commit(n);
        chk("mid_new", 32'(bcd), 32'h5678);

        // Reset in the middle of SHIFT.
        wait_commit(n);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        chk("mrst_bcd", 32'(bcd), 32'd0);
        chk("mrst_an", 32'(an), 32'hF);
        chk("mrst_seg", 32'(seg), 32'h7F);
        chk("mrst_busy", 32'(busy), 32'd1);
        tick(); tick();
        chk("mrst_bcd_hold", 32'(bcd), 32'd0);
        rst = 1'b0;
        tick();
        chk("mrst_an_rel", 32'(an), 32'hE);
        chk("mrst_seg_rel", 32'(seg), 32'(7'b1000000));
        n = 1;
        while (busy !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        chk("mrst_restart_len", 32'(n), 32'd15);
        tick();
        chk("mrst_bcd_after", 32'(bcd), 32'h5678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
